// File: rtl/uart_rx_if.sv
// Wishbone dbus bundle shared by the CPU (master) and the UART receiver (slave).
interface uart_rx_if;
   logic [31:0] wb_dbus_adr;
   logic [31:0] wb_dbus_dat;
   logic [3:0]  wb_dbus_sel;
   logic        wb_dbus_we;
   logic        wb_dbus_cyc;
   logic [31:0] rdt;
   logic        ack;

   modport master (
      output wb_dbus_adr, wb_dbus_dat, wb_dbus_sel, wb_dbus_we, wb_dbus_cyc,
      input  rdt, ack
   );

   modport slave (
      input  wb_dbus_adr, wb_dbus_dat, wb_dbus_sel, wb_dbus_we, wb_dbus_cyc,
      output rdt, ack
   );
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampling 8N1 UART receiver with a small byte FIFO and a
// DATA/STATUS register pair on the Wishbone dbus.
module uart_rx #(
   parameter int                AWIDTH = 8,
   parameter logic [AWIDTH-1:0] ADDR   = 8'h50,
   parameter int                DEPTH  = 4
) (
   input  logic      wb_clk,
   input  logic      wb_rst,
   uart_rx_if.slave  bus,
   input  logic      baud_en,
   input  logic      rx,
   output logic      ready,
   output logic      busy
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic          rx_meta, rxs, rxs_d;
   logic [1:0]    state;
   logic [3:0]    cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          brk;
   logic          push_req;
   logic          stop_sample;
   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wptr, rptr;
   logic [CW-1:0] count;
   logic [3:0]    count_w;
   logic          empty, full, pop, do_push, ovr_set, ferr_set, w1c;
   logic          ovr, ferr;
   logic          match;
   logic [31:0]   rd_data;
   logic          unused_bits;

   // Sync flops reset to the idle level so reset never fakes a start edge.
   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
         rxs_d   <= 1'b1;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
         rxs_d   <= rxs;
      end
   end

   assign stop_sample = (state == STOP) && !brk && baud_en && (cnt == 4'd15);
   assign ferr_set    = stop_sample && !rxs;
   assign busy        = (state != IDLE);

   // A low stop bit parks the FSM in STOP (brk) until the line returns high.
   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         bit_idx  <= 3'd0;
         shreg    <= 8'd0;
         brk      <= 1'b0;
         push_req <= 1'b0;
      end else begin
         push_req <= stop_sample && rxs;
         case (state)
            IDLE: begin
               if (rxs_d && !rxs) begin
                  cnt   <= 4'd0;
                  state <= START;
               end
            end
            START: begin
               if (baud_en) begin
                  if (cnt == 4'd7) begin
                     if (rxs) begin
                        state <= IDLE;
                     end else begin
                        cnt     <= 4'd0;
                        bit_idx <= 3'd0;
                        state   <= DATA;
                     end
                  end else begin
                     cnt <= cnt + 4'd1;
                  end
               end
            end
            DATA: begin
               if (baud_en) begin
                  if (cnt == 4'd15) begin
                     shreg <= {rxs, shreg[7:1]};
                     cnt   <= 4'd0;
                     if (bit_idx == 3'd7) state <= STOP;
                     else                 bit_idx <= bit_idx + 3'd1;
                  end else begin
                     cnt <= cnt + 4'd1;
                  end
               end
            end
            default: begin
               if (brk) begin
                  if (rxs) begin
                     brk   <= 1'b0;
                     state <= IDLE;
                  end
               end else if (baud_en) begin
                  if (cnt == 4'd15) begin
                     if (rxs) state <= IDLE;
                     else     brk   <= 1'b1;
                  end else begin
                     cnt <= cnt + 4'd1;
                  end
               end
            end
         endcase
      end
   end

   assign match = bus.wb_dbus_cyc && (bus.wb_dbus_adr[31:32-AWIDTH] == ADDR);

   always_ff @(posedge wb_clk) begin
      if (wb_rst) bus.ack <= 1'b0;
      else        bus.ack <= match && !bus.ack;
   end

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign ready   = !empty;
   assign count_w = 4'(count);
   assign pop     = bus.ack && !bus.wb_dbus_we && !bus.wb_dbus_adr[2] && !empty;
   assign do_push = push_req && (!full || pop);
   assign ovr_set = push_req && full && !pop;
   assign w1c     = bus.ack && bus.wb_dbus_we && bus.wb_dbus_adr[2] && bus.wb_dbus_sel[0];

   always_ff @(posedge wb_clk) begin
      if (do_push) mem[wptr] <= shreg;
   end

   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + PW'(1);
         if (pop)     rptr <= rptr + PW'(1);
         if (do_push && !pop)      count <= count + CW'(1);
         else if (!do_push && pop) count <= count - CW'(1);
      end
   end

   // A flag being set in the same cycle as its W1C clear stays set.
   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         ovr  <= 1'b0;
         ferr <= 1'b0;
      end else begin
         ovr  <= ovr_set  || (ovr  && !(w1c && bus.wb_dbus_dat[1]));
         ferr <= ferr_set || (ferr && !(w1c && bus.wb_dbus_dat[2]));
      end
   end

   always_comb begin
      rd_data = 32'd0;
      if (bus.wb_dbus_adr[2]) rd_data = {25'd0, count_w[2:0], 1'b0, ferr, ovr, !empty};
      else if (!empty)        rd_data = {24'd0, mem[rptr]};
   end

   assign bus.rdt = bus.ack ? rd_data : 32'd0;

   assign unused_bits = ^{bus.wb_dbus_dat[31:3], bus.wb_dbus_dat[0], bus.wb_dbus_sel[3:1],
                          bus.wb_dbus_adr[31-AWIDTH:3], bus.wb_dbus_adr[1:0]};

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: bus reads queue their expected data and a
// negedge monitor compares them whenever the receiver acks a read.
module tb_uart_rx;

   logic wb_clk  = 1'b0;
   logic wb_rst  = 1'b1;
   logic baud_en = 1'b1;
   logic rx      = 1'b1;
   logic ready, busy;

   int checks = 0;
   int errors = 0;
   logic [31:0] sb_q [$];
   logic [31:0] mon_exp;

   uart_rx_if bus ();

   uart_rx dut (
      .wb_clk  (wb_clk),
      .wb_rst  (wb_rst),
      .bus     (bus),
      .baud_en (baud_en),
      .rx      (rx),
      .ready   (ready),
      .busy    (busy)
   );

   always #5 wb_clk = ~wb_clk;

   // Monitor: every acked read consumes one expected value from the scoreboard.
   always @(negedge wb_clk) begin
      if (bus.ack && !bus.wb_dbus_we) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_read: got 0x%0h expected no read", bus.rdt);
         end else begin
            mon_exp = sb_q.pop_front();
            if (bus.rdt !== mon_exp) begin
               errors++;
               $display("[TB] FAIL read_adr_%0h: got 0x%0h expected 0x%0h",
                        bus.wb_dbus_adr, bus.rdt, mon_exp);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge wb_clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic bus_access(input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input logic we, output bit got);
      bus.wb_dbus_adr = adr;
      bus.wb_dbus_dat = dat;
      bus.wb_dbus_sel = sel;
      bus.wb_dbus_we  = we;
      bus.wb_dbus_cyc = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge wb_clk);
         #1;
         if (bus.ack) begin
            got = 1'b1;
            break;
         end
      end
      bus.wb_dbus_cyc = 1'b0;
      tick(1);
   endtask

   task automatic bus_read(input logic [31:0] adr, input logic [31:0] exp);
      bit got;
      sb_q.push_back(exp);
      bus_access(adr, 32'd0, 4'hf, 1'b0, got);
      if (!got) begin
         checks++;
         errors++;
         $display("[TB] FAIL read_ack_%0h: got no ack expected ack", adr);
         void'(sb_q.pop_front());
      end
   endtask

   task automatic bus_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      bit got;
      bus_access(adr, dat, sel, 1'b1, got);
      check_output("write_ack", {31'd0, got}, 32'd1);
   endtask

   // One 8N1 character at 16 clocks per bit; a low stop bit is left driven low.
   task automatic send_frame(input logic [7:0] data, input logic stop_val, input bit chk_start);
      rx = 1'b0;
      if (chk_start) begin
         tick(2);
         check_output("busy_before_start", {31'd0, busy}, 32'd0);
         tick(1);
         check_output("busy_at_start", {31'd0, busy}, 32'd1);
         tick(13);
      end else begin
         tick(16);
      end
      for (int i = 0; i < 8; i++) begin
         rx = data[i];
         tick(16);
      end
      rx = stop_val;
      tick(16);
      if (stop_val) tick(2);
   endtask

   initial begin
      bus.wb_dbus_adr = 32'd0;
      bus.wb_dbus_dat = 32'd0;
      bus.wb_dbus_sel = 4'd0;
      bus.wb_dbus_we  = 1'b0;
      bus.wb_dbus_cyc = 1'b0;

      // Reset state
      tick(2);
      for (int i = 0; i < 3; i++) begin
         check_output("rst_ready", {31'd0, ready}, 32'd0);
         check_output("rst_busy", {31'd0, busy}, 32'd0);
         check_output("rst_rdt", bus.rdt, 32'd0);
         tick(1);
      end
      wb_rst = 1'b0;
      tick(2);
      check_output("idle_ready", {31'd0, ready}, 32'd0);
      check_output("idle_rdt", bus.rdt, 32'd0);
      bus_read(32'h5000_0004, 32'h0);

      // Address outside the block is never acked
      bus.wb_dbus_adr = 32'h5100_0004;
      bus.wb_dbus_we  = 1'b0;
      bus.wb_dbus_cyc = 1'b1;
      tick(4);
      check_output("nomatch_ack", {31'd0, bus.ack}, 32'd0);
      bus.wb_dbus_cyc = 1'b0;
      tick(1);

      // 0x55 received and read back
      send_frame(8'h55, 1'b1, 1'b1);
      check_output("ready_55", {31'd0, ready}, 32'd1);
      check_output("busy_55", {31'd0, busy}, 32'd0);
      bus_read(32'h5000_0004, 32'h11);
      bus_read(32'h5000_0000, 32'h55);
      bus_read(32'h5000_0004, 32'h00);
      check_output("ready_after_pop", {31'd0, ready}, 32'd0);

      // 4-clock glitch rejected in START
      rx = 1'b0;
      tick(4);
      rx = 1'b1;
      tick(30);
      check_output("glitch_busy", {31'd0, busy}, 32'd0);
      check_output("glitch_ready", {31'd0, ready}, 32'd0);
      bus_read(32'h5000_0004, 32'h00);

      // 0xA3 with a long break instead of a stop bit
      send_frame(8'hA3, 1'b0, 1'b0);
      tick(40);
      check_output("break_busy", {31'd0, busy}, 32'd1);
      bus_read(32'h5000_0004, 32'h04);
      tick(230);
      check_output("break_busy_late", {31'd0, busy}, 32'd1);
      rx = 1'b1;
      tick(10);
      check_output("break_end_busy", {31'd0, busy}, 32'd0);
      check_output("break_ready", {31'd0, ready}, 32'd0);
      bus_read(32'h5000_0004, 32'h04);
      bus_write(32'h5000_0004, 32'h04, 4'h1);
      bus_read(32'h5000_0004, 32'h00);

      // Five bytes into a four-deep FIFO
      for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, 1'b0);
      tick(4);
      bus_read(32'h5000_0004, 32'h43);
      bus_write(32'h5000_0000, 32'hFF, 4'h1);
      bus_read(32'h5000_0004, 32'h43);
      for (int b = 1; b <= 4; b++) bus_read(32'h5000_0000, 32'(b));
      bus_read(32'h5000_0000, 32'h00);
      bus_read(32'h5000_0004, 32'h02);
      bus_write(32'h5000_0004, 32'h02, 4'h0);
      bus_read(32'h5000_0004, 32'h02);
      bus_write(32'h5000_0004, 32'h02, 4'h1);
      bus_read(32'h5000_0004, 32'h00);

      // Reset in the middle of 0xF0, then a clean 0x3C
      rx = 1'b0;
      tick(16 + 16 * 3);
      check_output("mid_frame_busy", {31'd0, busy}, 32'd1);
      wb_rst = 1'b1;
      rx     = 1'b1;
      tick(1);
      check_output("rst_mid_busy", {31'd0, busy}, 32'd0);
      check_output("rst_mid_ready", {31'd0, ready}, 32'd0);
      wb_rst = 1'b0;
      tick(1);
      bus_read(32'h5000_0004, 32'h00);
      tick(20);
      send_frame(8'h3C, 1'b1, 1'b0);
      check_output("ready_3c", {31'd0, ready}, 32'd1);
      bus_read(32'h5000_0000, 32'h3C);
      bus_read(32'h5000_0004, 32'h00);

      tick(4);
      check_output("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
